// File: rtl/mc_pkg.sv
// Shared encodings for the handshaked multicycle MIPS controller:
// FSM state codes, opcode/funct values, alusrcb/pcsrc/alucontrol encodings
// and the ALU-op class passed from the FSM to the ALU decoder.
package mc_pkg;

   localparam int unsigned STATE_W = 5;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_FETCH   = 5'd0;
   localparam state_t ST_DECODE  = 5'd1;
   localparam state_t ST_MEMADR  = 5'd2;
   localparam state_t ST_MEMRD   = 5'd3;
   localparam state_t ST_MEMWB   = 5'd4;
   localparam state_t ST_MEMWR   = 5'd5;
   localparam state_t ST_EXECUTE = 5'd6;
   localparam state_t ST_ALUWB   = 5'd7;
   localparam state_t ST_BRANCH  = 5'd8;
   localparam state_t ST_IEXEC   = 5'd9;
   localparam state_t ST_IWB     = 5'd10;
   localparam state_t ST_JUMP    = 5'd11;
   localparam state_t ST_FAULT   = 5'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] SRCB_B        = 3'b000;
   localparam logic [2:0] SRCB_FOUR     = 3'b001;
   localparam logic [2:0] SRCB_SIMM     = 3'b010;
   localparam logic [2:0] SRCB_SIMM_SH2 = 3'b011;
   localparam logic [2:0] SRCB_ZIMM     = 3'b100;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b1010;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b1011;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_OR    = 2'b11
   } aluop_e;

   // States that hold a memory request open and run the watchdog.
   function automatic logic is_mem_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
   endfunction

   function automatic logic funct_known(input logic [5:0] f);
      return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
             (f == FN_OR)  || (f == FN_SLT);
   endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's ALU-op class and the R-type funct field to
// alucontrol. Unknown funct codes decode to add so the output is never X.
//   funct_i      : instr[5:0]
//   aluop_i      : ALU-op class from the controller FSM
//   alucontrol_o : ALU operation, zero-extended to ALUCTRL_W
module mc_aludec
   import mc_pkg::*;
#(
   parameter int unsigned ALUCTRL_W = 4
) (
   input  logic [5:0]           funct_i,
   input  aluop_e               aluop_i,
   output logic [ALUCTRL_W-1:0] alucontrol_o
);

   logic [3:0] code;

   // Class select, with funct decode for R-type execution.
   always_comb begin
      code = ALU_ADD;
      unique case (aluop_i)
         ALUOP_ADD: code = ALU_ADD;
         ALUOP_SUB: code = ALU_SUB;
         ALUOP_OR:  code = ALU_OR;
         ALUOP_FUNCT: begin
            case (funct_i)
               FN_ADD:  code = ALU_ADD;
               FN_SUB:  code = ALU_SUB;
               FN_AND:  code = ALU_AND;
               FN_OR:   code = ALU_OR;
               FN_SLT:  code = ALU_SLT;
               default: code = ALU_ADD;
            endcase
         end
         default: code = ALU_ADD;
      endcase
   end

   assign alucontrol_o = ALUCTRL_W'(code);

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS controller with a req/ready memory handshake, wait-state
// insertion and a memory-timeout watchdog that parks the core in FAULT.
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN: unknown op (DECODE) or unknown
// funct (EXECUTE) traps to FAULT instead of falling through.
// Ports:
//   clk, reset (async, active-low)
//   op, funct, zero, mem_ready          : instruction fields / status
//   memreq, memwrite, pcen, irwrite,
//   regwrite                            : strobes, forced low in reset
//   alusrca, iord, memtoreg, regdst,
//   alusrcb, pcsrc, alucontrol          : datapath controls (Moore)
//   fault                               : sticky watchdog/trap flag
//   state_o                             : current state for debug
module mc_ctrl_hs
   import mc_pkg::*;
#(
   parameter int unsigned WAIT_W    = 4,
   parameter int unsigned MAX_WAIT  = 15,
   parameter int unsigned ALUCTRL_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           op,
   input  logic [5:0]           funct,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 memreq,
   output logic                 memwrite,
   output logic                 pcen,
   output logic                 irwrite,
   output logic                 regwrite,
   output logic                 alusrca,
   output logic                 iord,
   output logic                 memtoreg,
   output logic                 regdst,
   output logic [2:0]           alusrcb,
   output logic [1:0]           pcsrc,
   output logic [ALUCTRL_W-1:0] alucontrol,
   output logic                 fault,
   output logic [4:0]           state_o
);

   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              fault_q, fault_d;
   // Latched in DECODE: BNE (vs BEQ) or ORI (vs ADDI), since op is not
   // guaranteed stable after DECODE.
   logic              alt_q, alt_d;
   aluop_e            aluop;
   logic memreq_raw, memwrite_raw, pcen_raw, irwrite_raw, regwrite_raw;
   logic timeout;

   assign timeout = (wait_q == MAX_WAIT_C);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         wait_q  <= '0;
         fault_q <= 1'b0;
         alt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         fault_q <= fault_d;
         alt_q   <= alt_d;
      end
   end

   // Next state, watchdog counter and sticky fault.
   always_comb begin
      state_d = state_q;
      alt_d   = alt_q;
      unique case (state_q)
         ST_FETCH: begin
            if (mem_ready)    state_d = ST_DECODE;
            else if (timeout) state_d = ST_FAULT;
         end
         ST_DECODE: begin
            alt_d = (op == OP_BNE) || (op == OP_ORI);
            case (op)
               OP_LW, OP_SW:     state_d = ST_MEMADR;
               OP_RTYPE:         state_d = ST_EXECUTE;
               OP_BEQ, OP_BNE:   state_d = ST_BRANCH;
               OP_ADDI, OP_ORI:  state_d = ST_IEXEC;
               OP_J:             state_d = ST_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               default:          state_d = ST_FAULT;
`else
               default:          state_d = ST_FETCH;
`endif
            endcase
         end
         ST_MEMADR: state_d = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD: begin
            if (mem_ready)    state_d = ST_MEMWB;
            else if (timeout) state_d = ST_FAULT;
         end
         ST_MEMWB: state_d = ST_FETCH;
         ST_MEMWR: begin
            if (mem_ready)    state_d = ST_FETCH;
            else if (timeout) state_d = ST_FAULT;
         end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         ST_EXECUTE: state_d = funct_known(funct) ? ST_ALUWB : ST_FAULT;
`else
         ST_EXECUTE: state_d = ST_ALUWB;
`endif
         ST_ALUWB:  state_d = ST_FETCH;
         ST_BRANCH: state_d = ST_FETCH;
         ST_IEXEC:  state_d = ST_IWB;
         ST_IWB:    state_d = ST_FETCH;
         ST_JUMP:   state_d = ST_FETCH;
         ST_FAULT:  state_d = ST_FAULT;
         default:   state_d = ST_FETCH;
      endcase

      // Counts only while stalling in a memory state; any exit clears it.
      wait_d = '0;
      if (is_mem_state(state_q) && !mem_ready && (state_d == state_q))
         wait_d = wait_q + WAIT_W'(1);

      fault_d = fault_q | (state_d == ST_FAULT);
   end

   // Moore decode; only FETCH's pcen/irwrite look at mem_ready.
   always_comb begin
      memreq_raw   = 1'b0;
      memwrite_raw = 1'b0;
      pcen_raw     = 1'b0;
      irwrite_raw  = 1'b0;
      regwrite_raw = 1'b0;
      alusrca      = 1'b0;
      iord         = 1'b0;
      memtoreg     = 1'b0;
      regdst       = 1'b0;
      alusrcb      = SRCB_B;
      pcsrc        = PCSRC_ALU;
      aluop        = ALUOP_ADD;
      unique case (state_q)
         ST_FETCH: begin
            memreq_raw  = 1'b1;
            alusrcb     = SRCB_FOUR;
            pcen_raw    = mem_ready;
            irwrite_raw = mem_ready;
         end
         ST_DECODE: alusrcb = SRCB_SIMM_SH2;
         ST_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_SIMM;
         end
         ST_MEMRD: begin
            memreq_raw = 1'b1;
            iord       = 1'b1;
         end
         ST_MEMWB: begin
            regwrite_raw = 1'b1;
            memtoreg     = 1'b1;
         end
         ST_MEMWR: begin
            memreq_raw   = 1'b1;
            memwrite_raw = 1'b1;
            iord         = 1'b1;
         end
         ST_EXECUTE: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         ST_ALUWB: begin
            regwrite_raw = 1'b1;
            regdst       = 1'b1;
         end
         ST_BRANCH: begin
            alusrca  = 1'b1;
            aluop    = ALUOP_SUB;
            pcsrc    = PCSRC_ALUOUT;
            pcen_raw = alt_q ? ~zero : zero;
         end
         ST_IEXEC: begin
            alusrca = 1'b1;
            alusrcb = alt_q ? SRCB_ZIMM : SRCB_SIMM;
            aluop   = alt_q ? ALUOP_OR : ALUOP_ADD;
         end
         ST_IWB:  regwrite_raw = 1'b1;
         ST_JUMP: begin
            pcsrc    = PCSRC_JUMP;
            pcen_raw = 1'b1;
         end
         default: ;
      endcase
   end

   mc_aludec #(.ALUCTRL_W(ALUCTRL_W)) u_aludec (
      .funct_i      (funct),
      .aluop_i      (aluop),
      .alucontrol_o (alucontrol)
   );

   // Strobes are held low for as long as reset is asserted.
   assign memreq   = memreq_raw   & reset;
   assign memwrite = memwrite_raw & reset;
   assign pcen     = pcen_raw     & reset;
   assign irwrite  = irwrite_raw  & reset;
   assign regwrite = regwrite_raw & reset;
   assign fault    = fault_q;
   assign state_o  = state_q;

endmodule

// File: doc/mc_ctrl_hs.md
Name: mc_ctrl_hs

Overview:
Parametrised successor to the multicycle MIPS controller (main decoder, ALU decoder and PC-enable logic in one block). It drives the existing multicycle datapath against a variable-latency memory through a req/ready handshake, and inserts wait states as needed. It adds BNE and ORI, and a memory-timeout watchdog that parks the core in a FAULT state.

Parameters:
WAIT_W, 4, width of the memory wait-cycle counter
MAX_WAIT, 15, wait cycles without mem_ready that trigger FAULT (1..2^WAIT_W-1)
ALUCTRL_W, 4, alucontrol width (>=4)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
op  in  6  instr[31:26]
funct  in  6  instr[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
memreq  out  1  memory request valid
memwrite  out  1  write request (only with memreq)
pcen  out  1  PC register enable
irwrite, regwrite, alusrca, iord, memtoreg, regdst  out  1 each  datapath controls
alusrcb  out  3  000 B, 001 const 4, 010 signimm, 011 signimm<<2, 100 zeroimm
pcsrc  out  2  00 aluresult, 01 aluout, 10 jump target
alucontrol  out  ALUCTRL_W  0010 add, 1010 sub, 0000 and, 0001 or, 1011 slt
fault  out  1  sticky watchdog/trap flag
state_o  out  5  current state (debug)

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, wait counter=0, fault=0.
- While reset is low, all strobes (memreq, memwrite, pcen, irwrite, regwrite) are 0. Other outputs follow FETCH decode, so memreq=0 during reset.
- Outputs are Moore, decoded from state. The only exceptions are pcen and irwrite in FETCH, and state advance in wait states, which are gated by mem_ready.
- FETCH:
  - Drives memreq=1, iord=0, alusrca=0, alusrcb=001, pcsrc=00, add.
  - If mem_ready=1 in the same cycle: irwrite=1, pcen=1, go to DECODE.
  - Otherwise hold FETCH with no pcen and no irwrite.
- DECODE: alusrcb=011, add (branch target into aluout). Next state by op:
  - LW/SW (100011/101011) -> MEMADR
  - RTYPE 000000 -> EXECUTE
  - BEQ 000100 / BNE 000101 -> BRANCH
  - ADDI 001000 / ORI 001101 -> IEXEC
  - J 000010 -> JUMP
  - other -> FETCH
- MEMADR: alusrca=1, alusrcb=010, add. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: memreq=1, iord=1. Stays until mem_ready, then -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
- MEMWR: memreq=1, memwrite=1, iord=1. Stays until mem_ready, then -> FETCH.
- EXECUTE: alusrca=1, alusrcb=000, alucontrol decoded from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - other funct -> add (never X).
  - Next state ALUWB.
- ALUWB: regwrite=1, regdst=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=000, sub, pcsrc=01. pcen = zero for BEQ, ~zero for BNE. -> FETCH.
- IEXEC: alusrca=1. ADDI uses alusrcb=010, add; ORI uses alusrcb=100, or. -> IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JUMP: pcsrc=10, pcen=1 -> FETCH.
- Wait counter:
  - Cleared on entering any memory state (FETCH, MEMRD, MEMWR) and whenever mem_ready=1.
  - Increments each cycle in a memory state with mem_ready=0.
  - When the counter equals MAX_WAIT and mem_ready=0: next state FAULT, fault=1.
  - If mem_ready=1 on the same cycle the counter hits MAX_WAIT, ready wins and the transfer completes normally.
- FAULT: all strobes 0, memreq=0. Held until reset; fault stays 1.
- mem_ready while memreq=0 is ignored.
- An op change mid-instruction is only sampled in DECODE and MEMADR.

Optional Feature:
- Macro MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown op in DECODE, or an unknown funct in EXECUTE, goes to FAULT with fault=1.
  - With the macro defined, EXECUTE with an unknown funct does not go to ALUWB, so no register write occurs.
- Undefined: unknown op -> FETCH; unknown funct -> add.

Decomposition:
- Package mc_pkg holds:
  - state encodings (5-bit localparams)
  - opcode and funct constants
  - alusrcb, pcsrc and alucontrol encodings
- One natural sub-module: mc_aludec (funct + aluop -> alucontrol), parametrised by ALUCTRL_W.
- FSM, wait counter and output decode stay in mc_ctrl_hs.

Test Plan:
- Reset: reset=0 mid-MEMRD -> state_o=FETCH, fault=0, memreq=0 immediately. After release, memreq=1 the next cycle.
- Zero-wait ADDI (op=001000, mem_ready held 1):
  - FETCH 1 cycle with pcen=irwrite=1.
  - regwrite=1 in the 4th cycle (FETCH, DECODE, IEXEC, IWB).
- LW with 3 wait cycles at both FETCH and MEMRD:
  - memreq held for 4 cycles each, irwrite only on the ready cycle.
  - Total 5+3+3 = 11 cycles, with memtoreg=1 and regwrite=1 in MEMWB.
- BNE op=000101:
  - zero=0 -> pcen=1, pcsrc=01 in BRANCH.
  - zero=1 -> pcen=0.
  - BEQ gives the inverse.
- Timeout with MAX_WAIT=15, mem_ready=0 during MEMWR:
  - FAULT is entered after 16 cycles, then fault=1, memreq=0, and FAULT persists.
  - Repeat with ready asserted on cycle 16 -> no fault.
- ORI op=001101 -> alusrcb=100, alucontrol=0001 in IEXEC. With the macro defined, op=111111 -> FAULT.
